wb_write_sequencer: RTL and testbench

Write-side initiator for the core's single-write-port register file. Accepts up to two writeback results per cycle from the two superscalar execution lanes, queues them in program order, and drains exactly one write per cycle onto the register file's write port (WE3/WA3/WD3). Also exposes a two-port pending-write lookup so decode can forward or stall on registers whose writes are still queued.

---
 rtl/wb_write_sequencer.sv | 129 ++++++++++++
 tb/tb_wb_write_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/wb_write_sequencer.sv
// Writeback sequencer: queues up to two lane results per cycle in program
// order and drains one register-file write per cycle, with pending-write lookup.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   l0_valid/l0_addr/l0_data     lane 0 result (older)
//   l1_valid/l1_addr/l1_data     lane 1 result (younger)
//   in_ready                     room for two results this cycle
//   we_o/wa_o/wd_o               register file write port (WE3/WA3/WD3)
//   q_addr1/q_addr2              decode lookup addresses
//   q_hit1/q_hit2                queued write pending for that address
//   q_data1/q_data2              data of youngest matching queued write
//   count                        occupied entries
module wb_write_sequencer #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     l0_valid,
  input  logic [AW-1:0]            l0_addr,
  input  logic [DW-1:0]            l0_data,
  input  logic                     l1_valid,
  input  logic [AW-1:0]            l1_addr,
  input  logic [DW-1:0]            l1_data,
  output logic                     in_ready,
  output logic                     we_o,
  output logic [AW-1:0]            wa_o,
  output logic [DW-1:0]            wd_o,
  input  logic [AW-1:0]            q_addr1,
  input  logic [AW-1:0]            q_addr2,
  output logic                     q_hit1,
  output logic                     q_hit2,
  output logic [DW-1:0]            q_data1,
  output logic [DW-1:0]            q_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  logic          acc0;
  logic          acc1;
  logic          pop;
  logic [CW-1:0] npush;
  logic [PW-1:0] slot1;

  // Readiness uses only the registered count; a same-cycle pop
  // does not make room early.
  assign in_ready = (CW'(DEPTH) - cnt) >= CW'(2);

  // Writes to x0 are architecturally void and never occupy a slot.
  assign acc0 = l0_valid && in_ready && (l0_addr != '0);
  assign acc1 = l1_valid && in_ready && (l1_addr != '0);

  assign npush = CW'(acc0) + CW'(acc1);
  assign pop   = (cnt != '0);

  // Lane 1 lands after lane 0 only when lane 0 actually took a slot.
  assign slot1 = wr_ptr + PW'(acc0);

  assign count = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(npush);
      rd_ptr <= rd_ptr + PW'(pop);
      cnt    <= cnt + npush - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (acc0) begin
      addr_q[wr_ptr] <= l0_addr;
      data_q[wr_ptr] <= l0_data;
    end
    if (acc1) begin
      addr_q[slot1] <= l1_addr;
      data_q[slot1] <= l1_data;
    end
  end

  // The register file always accepts, so the head is the write.
  always_comb begin
    we_o = pop;
    wa_o = '0;
    wd_o = '0;
    if (pop) begin
      wa_o = addr_q[rd_ptr];
      wd_o = data_q[rd_ptr];
    end
  end

  // Scan oldest to youngest; the last match seen is the youngest.
  always_comb begin
    logic [PW-1:0] idx;
    q_hit1  = 1'b0;
    q_hit2  = 1'b0;
    q_data1 = '0;
    q_data2 = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < cnt) begin
        if ((q_addr1 != '0) && (addr_q[idx] == q_addr1)) begin
          q_hit1  = 1'b1;
          q_data1 = data_q[idx];
        end
        if ((q_addr2 != '0) && (addr_q[idx] == q_addr2)) begin
          q_hit2  = 1'b1;
          q_data2 = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_write_sequencer.sv
// Self-checking bench for wb_write_sequencer: directed steps then random
// traffic, checked every cycle against an in-order queue model.
module tb_wb_write_sequencer;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          l0_valid, l1_valid;
  logic [AW-1:0] l0_addr, l1_addr;
  logic [DW-1:0] l0_data, l1_data;
  logic          in_ready, we_o;
  logic [AW-1:0] wa_o;
  logic [DW-1:0] wd_o;
  logic [AW-1:0] q_addr1, q_addr2;
  logic          q_hit1, q_hit2;
  logic [DW-1:0] q_data1, q_data2;
  logic [CW-1:0] count;

  wb_write_sequencer #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .l0_valid(l0_valid), .l0_addr(l0_addr), .l0_data(l0_data),
    .l1_valid(l1_valid), .l1_addr(l1_addr), .l1_data(l1_data),
    .in_ready(in_ready),
    .we_o(we_o), .wa_o(wa_o), .wd_o(wd_o),
    .q_addr1(q_addr1), .q_addr2(q_addr2),
    .q_hit1(q_hit1), .q_hit2(q_hit2),
    .q_data1(q_data1), .q_data2(q_data2),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t mq[$];
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Youngest pending write to address a, if any.
  task automatic ref_lookup(input logic [AW-1:0] a, output logic h,
                            output logic [DW-1:0] d);
    h = 1'b0;
    d = '0;
    if (a != '0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].a == a) begin
          h = 1'b1;
          d = mq[i].d;
          break;
        end
      end
    end
  endtask

  task automatic check_all();
    int            n;
    logic          h;
    logic [DW-1:0] d;
    n = mq.size();
    chk("count", 64'(count), 64'(n));
    chk("in_ready", 64'(in_ready), 64'((DEPTH - n) >= 2));
    chk("we_o", 64'(we_o), 64'(n != 0));
    chk("wa_o", 64'(wa_o), n != 0 ? 64'(mq[0].a) : 64'd0);
    chk("wd_o", 64'(wd_o), n != 0 ? 64'(mq[0].d) : 64'd0);
    ref_lookup(q_addr1, h, d);
    chk("q_hit1", 64'(q_hit1), 64'(h));
    chk("q_data1", 64'(q_data1), 64'(d));
    ref_lookup(q_addr2, h, d);
    chk("q_hit2", 64'(q_hit2), 64'(h));
    chk("q_data2", 64'(q_data2), 64'(d));
  endtask

  // Drive one cycle of inputs at negedge, advance model at posedge,
  // check outputs at the following negedge.
  task automatic step(input bit r,
                      input bit v0, input logic [AW-1:0] a0,
                      input logic [DW-1:0] d0,
                      input bit v1, input logic [AW-1:0] a1,
                      input logic [DW-1:0] d1,
                      input logic [AW-1:0] qa1, input logic [AW-1:0] qa2);
    bit   rdy;
    ent_t e;
    rst = r;
    l0_valid = v0; l0_addr = a0; l0_data = d0;
    l1_valid = v1; l1_addr = a1; l1_data = d1;
    q_addr1 = qa1; q_addr2 = qa2;
    rdy = (DEPTH - mq.size()) >= 2;
    @(posedge clk);
    if (r) begin
      mq.delete();
    end else begin
      if (mq.size() != 0) void'(mq.pop_front());
      if (rdy && v0 && a0 != '0) begin
        e.a = a0; e.d = d0; mq.push_back(e);
      end
      if (rdy && v1 && a1 != '0) begin
        e.a = a1; e.d = d1; mq.push_back(e);
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input logic [AW-1:0] qa1, input logic [AW-1:0] qa2);
    step(0, 0, '0, '0, 0, '0, '0, qa1, qa2);
  endtask

  initial begin
    rst = 1'b1;
    l0_valid = 0; l0_addr = '0; l0_data = '0;
    l1_valid = 0; l1_addr = '0; l1_data = '0;
    q_addr1 = '0; q_addr2 = '0;
    @(negedge clk);
    step(1, 0, '0, '0, 0, '0, '0, 5'd0, 5'd0);
    step(1, 1, 5'd3, 32'h1, 1, 5'd4, 32'h2, 5'd3, 5'd4);

    // single push
    step(0, 1, 5'd3, 32'hAAAA_0001, 0, '0, '0, 5'd3, 5'd0);
    idle(5'd3, 5'd0);

    // same destination on both lanes
    step(0, 1, 5'd5, 32'h11, 1, 5'd5, 32'h22, 5'd5, 5'd5);
    idle(5'd5, 5'd0);
    idle(5'd5, 5'd0);

    // x0 dropped
    step(0, 1, 5'd0, 32'hDEAD, 1, 5'd7, 32'h77, 5'd0, 5'd7);
    idle(5'd0, 5'd7);

    // back-to-back dual pushes, third is refused
    step(0, 1, 5'd1, 32'h101, 1, 5'd2, 32'h102, 5'd1, 5'd2);
    step(0, 1, 5'd3, 32'h103, 1, 5'd4, 32'h104, 5'd3, 5'd4);
    step(0, 1, 5'd5, 32'h105, 1, 5'd6, 32'h106, 5'd5, 5'd6);
    for (int i = 0; i < 4; i++) idle(5'd4, 5'd1);

    // lookup picks youngest match
    step(0, 1, 5'd9, 32'h1, 1, 5'd4, 32'h2, 5'd9, 5'd4);
    step(0, 1, 5'd4, 32'h2, 1, 5'd9, 32'h3, 5'd9, 5'd8);

    // reset with entries queued, then a normal push
    step(1, 0, '0, '0, 0, '0, '0, 5'd9, 5'd4);
    step(0, 1, 5'd12, 32'hC0DE, 0, '0, '0, 5'd12, 5'd0);
    idle(5'd12, 5'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0,
           1'($urandom), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
